dcache_refill_ctrl: RTL and testbench
=====================================

Name: dcache_refill_ctrl

Overview:
- Miss/write-back controller directly downstream of the 2-way data cache; owns the only path to main memory.
- Takes one miss request at a time: dirty-victim write-back, read refill or write-through.
- Drives a single-word req/ready memory handshake and stalls the CPU until the cache has its refill word.

Parameters:
XLEN, 32, data and address width
WB_EN_DEFAULT, 1, 1 = honour victim_dirty; 0 = never issue write-backs (debug)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
miss_req  in  1  cache miss this cycle; sampled only in IDLE
miss_we  in  1  1 = write miss (no-write-allocate), 0 = read miss
miss_addr  in  XLEN  missing address
miss_wdata  in  XLEN  store data for a write miss
victim_dirty  in  1  selected victim way is valid and dirty
victim_addr  in  XLEN  victim address, rebuilt from tag/set
victim_data  in  XLEN  victim data word
stall  out  1  freeze CPU pipeline
fill_valid  out  1  one-cycle pulse: cache installs fill_data at fill_addr
fill_addr  out  XLEN  refill address
fill_data  out  XLEN  refill word
mem_req  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  XLEN  word-aligned memory address
mem_wdata  out  XLEN  memory write data
mem_ready  in  1  memory accepts or completes the request this cycle
mem_rdata  in  XLEN  read data, valid when mem_ready=1 and mem_we=0
perf_miss_cnt  out  32  read-miss counter (optional feature)
perf_wb_cnt  out  32  write-back counter (optional feature)

Behaviour:
- States: IDLE, WB, RD, WT, FILL. Registered state; outputs decoded from state and latched registers.
- Reset (rst=0, async): state=IDLE; all latches and counters cleared; stall, fill_valid, mem_req, mem_we=0; mem_addr, mem_wdata, fill_addr, fill_data=0.
- Reset mid-transaction: abort immediately. mem_req drops in the same cycle. No fill is issued. Memory must tolerate an abandoned request.
- IDLE with miss_req=1: latch miss_addr, miss_we, miss_wdata, victim_*.
  - Next state: miss_we=1 -> WT; else if victim_dirty and WB_EN_DEFAULT -> WB; else RD.
- IDLE with miss_req=0: stay; stall=0.
- stall = (state!=IDLE) | (state==IDLE & miss_req). This is a combinational path from miss_req and is required.
- WB: mem_req=1, mem_we=1, mem_addr=victim_addr_q, mem_wdata=victim_data_q. On mem_ready=1 -> RD.
- RD: mem_req=1, mem_we=0, mem_addr=miss_addr_q. On mem_ready=1: capture mem_rdata -> FILL.
- WT: mem_req=1, mem_we=1, mem_addr=miss_addr_q, mem_wdata=miss_wdata_q. On mem_ready=1 -> IDLE. No fill.
- FILL: fill_valid=1 for exactly one cycle, with fill_addr=miss_addr_q and fill_data=captured word; stall=1; then IDLE.
- Handshake:
  - mem_req and all mem_* outputs are held stable until the edge where mem_ready=1.
  - mem_ready while mem_req=0 is ignored.
  - mem_req never drops without ready, except on reset.
- Addressing: mem_addr[1:0] forced to 00. No byte enables; always full-word transfers.
- miss_req outside IDLE is ignored. The cache re-presents the access after stall falls.
- Latency, zero-wait memory:
  - Clean read miss: stall high 3 cycles (IDLE-accept, RD, FILL).
  - Dirty read miss: 4 cycles.
  - Write miss: 2 cycles.
  - Each memory wait cycle adds 1.

Optional Feature:
- Macro: DCACHE_PERF_CNT_EN.
- Defined: perf_miss_cnt increments on each RD->FILL transition; perf_wb_cnt increments on each completed WB. Both are 32-bit wrapping counters (0xFFFFFFFF -> 0), cleared by reset.
- Undefined: both ports tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package dcache_pkg holds the state enum typedef (refill_state_t) and the word-offset constant (WORD_OFF=2), reused by data_cache and any future line-based refill.
- No sub-module is needed; a single FSM plus latch registers.

Test Plan:
- Clean read miss: miss_addr=0x0000_1004, victim_dirty=0, mem_ready=1 in the first RD cycle, mem_rdata=0xDEADBEEF -> one mem read at 0x1004; fill_valid pulse with fill_data=0xDEADBEEF; stall high 3 cycles.
- Dirty read miss: victim_addr=0x0000_0804, victim_data=0x1234_5678; memory 2 wait cycles per request -> write 0x12345678@0x804 first, then read @0x1004; stall high 8 cycles.
- Write miss: miss_we=1, miss_addr=0x2002, miss_wdata=0xA5A5A5A5 -> mem write at 0x2000 with 0xA5A5A5A5; no fill_valid; stall 2 cycles.
- Ignored request: miss_req pulsed again during RD with a different address -> no second transaction; mem_addr stable until ready.
- Reset mid-WB: rst=0 while in WB with mem_ready=0 -> mem_req=0 immediately; IDLE after release; no fill_valid.
- With DCACHE_PERF_CNT_EN: 3 clean plus 2 dirty read misses -> perf_miss_cnt=5, perf_wb_cnt=2.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache miss path: refill FSM encoding and word offset.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcache_pkg;

  // Refill/write-back controller states. Any future line-based refill reuses this set.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WB   = 3'd1,
    S_RD   = 3'd2,
    S_WT   = 3'd3,
    S_FILL = 3'd4
  } refill_state_t;

  // Byte-offset bits inside one memory word. Memory only sees word-aligned addresses.
  localparam int WORD_OFF = 2;

endpackage

// File: rtl/dcache_refill_ctrl.sv
// Miss / write-back controller: the 2-way data cache's only path to main memory.
// Latency (zero-wait memory): clean read miss 3 stall cycles, dirty read miss 4, write miss 2.
// Backpressure: each mem_req is held with stable mem_* until mem_ready; CPU stalled meanwhile.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   miss_req/we/addr/wdata    miss from the cache, sampled only in IDLE
//   victim_dirty/addr/data    victim way to write back before a read refill
//   stall                     freezes the CPU pipeline (combinational from miss_req in IDLE)
//   fill_valid/addr/data      one-cycle install pulse towards the cache
//   mem_req/we/addr/wdata     single-word request to memory, mem_ready/mem_rdata back
//   perf_miss_cnt/perf_wb_cnt counters, present only when DCACHE_PERF_CNT_EN is defined
module dcache_refill_ctrl
  import dcache_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter bit WB_EN_DEFAULT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            miss_req,
  input  logic            miss_we,
  input  logic [XLEN-1:0] miss_addr,
  input  logic [XLEN-1:0] miss_wdata,
  input  logic            victim_dirty,
  input  logic [XLEN-1:0] victim_addr,
  input  logic [XLEN-1:0] victim_data,
  output logic            stall,
  output logic            fill_valid,
  output logic [XLEN-1:0] fill_addr,
  output logic [XLEN-1:0] fill_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [31:0]     perf_miss_cnt,
  output logic [31:0]     perf_wb_cnt
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'((1 << WORD_OFF) - 1);

  refill_state_t   state;
  logic [XLEN-1:0] miss_addr_q;

  // The only combinational output: the pipeline must freeze in the same cycle the miss appears.
  assign stall = (state != S_IDLE) | miss_req;

  // Single FSM with registered memory/fill outputs. Victim and store data are captured
  // straight into mem_wdata, so only the miss address needs its own latch (it is
  // needed again for the read after a write-back and for the fill).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      miss_addr_q <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      fill_valid  <= 1'b0;
      fill_addr   <= '0;
      fill_data   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          fill_valid <= 1'b0;
          if (miss_req) begin
            miss_addr_q <= miss_addr;
            mem_req     <= 1'b1;
            if (miss_we) begin
              state     <= S_WT;
              mem_we    <= 1'b1;
              mem_addr  <= miss_addr & ALIGN_MASK;
              mem_wdata <= miss_wdata;
            end else if (victim_dirty && WB_EN_DEFAULT) begin
              state     <= S_WB;
              mem_we    <= 1'b1;
              mem_addr  <= victim_addr & ALIGN_MASK;
              mem_wdata <= victim_data;
            end else begin
              state     <= S_RD;
              mem_we    <= 1'b0;
              mem_addr  <= miss_addr & ALIGN_MASK;
              mem_wdata <= '0;
            end
          end
        end
        S_WB: begin
          if (mem_ready) begin
            // Victim is safe in memory; turn the same request into the refill read.
            state     <= S_RD;
            mem_we    <= 1'b0;
            mem_addr  <= miss_addr_q & ALIGN_MASK;
            mem_wdata <= '0;
          end
        end
        S_RD: begin
          if (mem_ready) begin
            state      <= S_FILL;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            fill_valid <= 1'b1;
            fill_addr  <= miss_addr_q;
            fill_data  <= mem_rdata;
          end
        end
        S_WT: begin
          if (mem_ready) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end
        end
        S_FILL: begin
          state      <= S_IDLE;
          fill_valid <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          mem_req    <= 1'b0;
          mem_we     <= 1'b0;
          fill_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // Free-running wrapping counters of completed refill reads and write-backs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_miss_cnt <= '0;
      perf_wb_cnt   <= '0;
    end else begin
      if (state == S_RD && mem_ready) perf_miss_cnt <= perf_miss_cnt + 32'd1;
      if (state == S_WB && mem_ready) perf_wb_cnt   <= perf_wb_cnt + 32'd1;
    end
  end
`else
  assign perf_miss_cnt = '0;
  assign perf_wb_cnt   = '0;
`endif

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Scoreboard bench for dcache_refill_ctrl: memory transactions and fills are predicted
// per miss, then popped and compared by an independent monitor as they appear.
// A small memory responder inserts a configurable number of wait cycles per request.
module tb_dcache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_req = 1'b0, miss_we = 1'b0;
  logic [31:0] miss_addr = '0, miss_wdata = '0;
  logic        victim_dirty = 1'b0;
  logic [31:0] victim_addr = '0, victim_data = '0;
  logic        stall, fill_valid, mem_req, mem_we;
  logic [31:0] fill_addr, fill_data, mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] perf_miss_cnt, perf_wb_cnt;

  dcache_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_we(miss_we), .miss_addr(miss_addr), .miss_wdata(miss_wdata),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
    .stall(stall), .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .perf_miss_cnt(perf_miss_cnt), .perf_wb_cnt(perf_wb_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_txn_t;

  mem_txn_t    exp_mem[$];
  logic [31:0] exp_fill_addr[$];
  logic [31:0] exp_fill_data[$];

  int vectors = 0;
  int miscompares = 0;

  int          mem_wait = 0;
  logic [31:0] next_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  // Memory responder: ready after mem_wait idle cycles of each request.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_ready) cnt = 0;          // a handshake completed on the last edge
      if (mem_req && rst) begin
        if (cnt >= mem_wait) mem_ready = 1'b1;
        else begin
          mem_ready = 1'b0;
          cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        cnt = 0;
      end
      mem_rdata = next_rdata;
    end
  end

  // Monitor: pops expectations on every handshake / fill and checks request stability.
  initial begin
    logic        hold_vld;
    logic        hold_we;
    logic [31:0] hold_addr, hold_wdata;
    mem_txn_t    t;
    hold_vld = 1'b0;
    hold_we = 1'b0;
    hold_addr = '0;
    hold_wdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        hold_vld = 1'b0;
      end else begin
        if (hold_vld && mem_req) begin
          check("hold_we", {31'd0, mem_we}, {31'd0, hold_we});
          check("hold_addr", mem_addr, hold_addr);
          check("hold_wdata", mem_wdata, hold_wdata);
        end else if (hold_vld) begin
          fail_now("mem_req dropped without ready");
        end
        if (mem_req && mem_ready) begin
          if (exp_mem.size() == 0) fail_now("unexpected memory transaction");
          else begin
            t = exp_mem.pop_front();
            check("mem_we", {31'd0, mem_we}, {31'd0, t.we});
            check("mem_addr", mem_addr, t.addr);
            if (t.we) check("mem_wdata", mem_wdata, t.wdata);
          end
        end
        hold_vld   = mem_req && !mem_ready;
        hold_we    = mem_we;
        hold_addr  = mem_addr;
        hold_wdata = mem_wdata;
        if (fill_valid) begin
          if (exp_fill_addr.size() == 0) fail_now("unexpected fill_valid");
          else begin
            check("fill_addr", fill_addr, exp_fill_addr.pop_front());
            check("fill_data", fill_data, exp_fill_data.pop_front());
          end
        end
      end
    end
  end

  // Issue one miss, predict its traffic, and count stall cycles.
  // poke > 0 re-asserts miss_req with another address at that stall cycle.
  task automatic do_miss(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic dirty, input logic [31:0] vaddr, input logic [31:0] vdata,
                         input logic [31:0] rdata, input int waits, input int exp_stall,
                         input int poke, input string name);
    int cycles;
    mem_txn_t t;
    @(negedge clk);
    mem_wait   = waits;
    next_rdata = rdata;
    if (we) begin
      t.we = 1'b1; t.addr = {addr[31:2], 2'b00}; t.wdata = wdata;
      exp_mem.push_back(t);
    end else begin
      if (dirty) begin
        t.we = 1'b1; t.addr = {vaddr[31:2], 2'b00}; t.wdata = vdata;
        exp_mem.push_back(t);
      end
      t.we = 1'b0; t.addr = {addr[31:2], 2'b00}; t.wdata = '0;
      exp_mem.push_back(t);
      exp_fill_addr.push_back(addr);
      exp_fill_data.push_back(rdata);
    end
    miss_req = 1'b1; miss_we = we; miss_addr = addr; miss_wdata = wdata;
    victim_dirty = dirty; victim_addr = vaddr; victim_data = vdata;
    #1;
    cycles = 0;
    while (stall && cycles < 200) begin
      cycles++;
      @(negedge clk);
      miss_req = 1'b0;
      if (poke > 0 && cycles == poke) begin
        miss_req  = 1'b1;
        miss_we   = 1'b0;
        miss_addr = addr + 32'h100;
      end
      #1;
    end
    miss_req = 1'b0;
    check({name, " stall cycles"}, cycles, exp_stall);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst stall", {31'd0, stall}, 32'd0);
    check("rst fill_valid", {31'd0, fill_valid}, 32'd0);
    check("rst mem_req", {31'd0, mem_req}, 32'd0);
    check("rst mem_we", {31'd0, mem_we}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst fill_addr", fill_addr, 32'd0);
    check("rst fill_data", fill_data, 32'd0);
    check("rst perf_miss", perf_miss_cnt, 32'd0);
    check("rst perf_wb", perf_wb_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Clean read miss, zero-wait memory: IDLE, RD, FILL
    do_miss(1'b0, 32'h0000_1004, 32'h0, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 3, 0, "clean");
    // Dirty read miss, two wait cycles per request: 1 + 3 + 3 + 1
    do_miss(1'b0, 32'h0000_1004, 32'h0, 1'b1, 32'h0000_0804, 32'h1234_5678,
            32'hCAFE_F00D, 2, 8, 0, "dirty");
    // Write miss on an unaligned address, no fill: IDLE, WT
    do_miss(1'b1, 32'h0000_2002, 32'hA5A5_A5A5, 1'b1, 32'h0000_0900, 32'h1111_1111,
            32'h0, 0, 2, 0, "write");
    // Second miss_req during RD must be ignored: 1 + 3 + 1
    do_miss(1'b0, 32'h0000_3008, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0BAD_F00D, 2, 5, 1, "ignored");

    // Reset while a write-back is waiting for memory
    @(negedge clk);
    mem_wait = 10;
    miss_req = 1'b1; miss_we = 1'b0; miss_addr = 32'h0000_4000;
    victim_dirty = 1'b1; victim_addr = 32'h0000_0A00; victim_data = 32'h5555_AAAA;
    @(negedge clk);
    miss_req = 1'b0;
    #1;
    check("midwb mem_req", {31'd0, mem_req}, 32'd1);
    check("midwb mem_we", {31'd0, mem_we}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort mem_req", {31'd0, mem_req}, 32'd0);
    check("abort stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("post-abort mem_req", {31'd0, mem_req}, 32'd0);
      check("post-abort fill_valid", {31'd0, fill_valid}, 32'd0);
    end
    victim_dirty = 1'b0;

    // Counter run after reset: 3 clean + 2 dirty read misses
    do_miss(1'b0, 32'h0000_5000, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0000_0001, 0, 3, 0, "c1");
    do_miss(1'b0, 32'h0000_5004, 32'h0, 1'b1, 32'h0000_6004, 32'h0000_00A1,
            32'h0000_0002, 0, 4, 0, "d1");
    do_miss(1'b0, 32'h0000_5008, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0000_0003, 1, 4, 0, "c2");
    do_miss(1'b0, 32'h0000_500C, 32'h0, 1'b1, 32'h0000_600C, 32'h0000_00A2,
            32'h0000_0004, 1, 6, 0, "d2");
    do_miss(1'b0, 32'h0000_5010, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0000_0005, 0, 3, 0, "c3");
`ifdef DCACHE_PERF_CNT_EN
    check("perf_miss_cnt", perf_miss_cnt, 32'd5);
    check("perf_wb_cnt", perf_wb_cnt, 32'd2);
`else
    check("perf_miss_cnt", perf_miss_cnt, 32'd0);
    check("perf_wb_cnt", perf_wb_cnt, 32'd0);
`endif

    repeat (3) @(negedge clk);
    #2;
    check("leftover mem txns", exp_mem.size(), 32'd0);
    check("leftover fills", exp_fill_addr.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
